// File: rtl/alu_issue_stage_if.sv
// ID/EX issue-stage bundle: ID-side instruction fields, operands and forwarding
// controls in, registered ALU operation and operands out.
interface alu_issue_stage_if #(
    parameter int bit_size = 32,
    parameter int cnt_size = 8
);
    logic                valid_in;
    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic [4:0]          shamt_in;
    logic [15:0]         imm16;
    logic [bit_size-1:0] rs_data;
    logic [bit_size-1:0] rt_data;
    logic [1:0]          fwd_a_sel;
    logic [1:0]          fwd_b_sel;
    logic [bit_size-1:0] exmem_result;
    logic [bit_size-1:0] memwb_result;
    logic                stall;
    logic                flush;
    logic [3:0]          ALUOp;
    logic [bit_size-1:0] src1;
    logic [bit_size-1:0] src2;
    logic [4:0]          shamt;
    logic [bit_size-1:0] rt_fwd;
    logic                valid_out;
    logic                illegal;
    logic [cnt_size-1:0] illegal_cnt;

    modport master (
        output valid_in, opcode, funct, shamt_in, imm16, rs_data, rt_data,
               fwd_a_sel, fwd_b_sel, exmem_result, memwb_result, stall, flush,
        input  ALUOp, src1, src2, shamt, rt_fwd, valid_out, illegal, illegal_cnt
    );

    modport slave (
        input  valid_in, opcode, funct, shamt_in, imm16, rs_data, rt_data,
               fwd_a_sel, fwd_b_sel, exmem_result, memwb_result, stall, flush,
        output ALUOp, src1, src2, shamt, rt_fwd, valid_out, illegal, illegal_cnt
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX issue register: decodes opcode/funct into an ALU operation, selects
// forwarded operands and registers everything toward the EX-stage ALU.
module alu_issue_stage #(
    parameter int bit_size = 32,
    parameter int cnt_size = 8
) (
    input  logic             clk,
    input  logic             rst,
    alu_issue_stage_if.slave bus
);

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_SLL = 4'b1001,
        ALU_NOR = 4'b1100,
        ALU_XOR = 4'b1101,
        ALU_SRL = 4'b1110
    } alu_op_e;

    typedef enum logic [1:0] {
        SRC2_B,
        SRC2_SE,
        SRC2_ZE
    } src2_sel_e;

    localparam logic [cnt_size-1:0] CNT_ONE = {{(cnt_size-1){1'b0}}, 1'b1};

    logic [bit_size-1:0] a_val, b_val, se_imm, ze_imm;
    logic [bit_size-1:0] op_src1, op_src2;

    alu_op_e   dec_op;
    logic      dec_legal;
    logic      dec_src1_zero;
    src2_sel_e dec_src2_sel;
    logic [4:0] dec_shamt;

    logic                valid_q,       valid_d;
    alu_op_e             alu_op_q,      alu_op_d;
    logic [bit_size-1:0] src1_q,        src1_d;
    logic [bit_size-1:0] src2_q,        src2_d;
    logic [4:0]          shamt_q,       shamt_d;
    logic [bit_size-1:0] rt_fwd_q,      rt_fwd_d;
    logic                illegal_q,     illegal_d;
    logic [cnt_size-1:0] illegal_cnt_q, illegal_cnt_d;

    assign se_imm = {{(bit_size-16){bus.imm16[15]}}, bus.imm16};
    assign ze_imm = {{(bit_size-16){1'b0}}, bus.imm16};

    // Encodings 00 and 11 both take the register-file value.
    always_comb begin
        case (bus.fwd_a_sel)
            2'b01:   a_val = bus.exmem_result;
            2'b10:   a_val = bus.memwb_result;
            default: a_val = bus.rs_data;
        endcase
        case (bus.fwd_b_sel)
            2'b01:   b_val = bus.exmem_result;
            2'b10:   b_val = bus.memwb_result;
            default: b_val = bus.rt_data;
        endcase
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statements can leave a value unassigned (latch).
    always_comb begin
        dec_legal     = 1'b1;
        dec_op        = ALU_AND;
        dec_src1_zero = 1'b0;
        dec_src2_sel  = SRC2_B;
        dec_shamt     = 5'd0;
        case (bus.opcode)
            6'b000000: begin
                case (bus.funct)
                    6'b100000, 6'b100001: dec_op = ALU_ADD;
                    6'b100010, 6'b100011: dec_op = ALU_SUB;
                    6'b100100:            dec_op = ALU_AND;
                    6'b100101:            dec_op = ALU_OR;
                    6'b100110:            dec_op = ALU_XOR;
                    6'b100111:            dec_op = ALU_NOR;
                    6'b101010:            dec_op = ALU_SLT;
                    6'b000000: begin
                        dec_op        = ALU_SLL;
                        dec_src1_zero = 1'b1;
                        dec_shamt     = bus.shamt_in;
                    end
                    6'b000010: begin
                        dec_op        = ALU_SRL;
                        dec_src1_zero = 1'b1;
                        dec_shamt     = bus.shamt_in;
                    end
                    default:              dec_legal = 1'b0;
                endcase
            end
            6'b001000, 6'b001001, 6'b100011, 6'b101011: begin
                dec_op       = ALU_ADD;
                dec_src2_sel = SRC2_SE;
            end
            6'b001010: begin
                dec_op       = ALU_SLT;
                dec_src2_sel = SRC2_SE;
            end
            6'b001100: begin
                dec_op       = ALU_AND;
                dec_src2_sel = SRC2_ZE;
            end
            6'b001101: begin
                dec_op       = ALU_OR;
                dec_src2_sel = SRC2_ZE;
            end
            6'b001110: begin
                dec_op       = ALU_XOR;
                dec_src2_sel = SRC2_ZE;
            end
            6'b000100, 6'b000101: dec_op = ALU_SUB;
            6'b001111: begin
                // lui is issued as a left shift of the zero-extended immediate by 16
                dec_op        = ALU_SLL;
                dec_src1_zero = 1'b1;
                dec_src2_sel  = SRC2_ZE;
                dec_shamt     = 5'd16;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        op_src1 = dec_src1_zero ? '0 : a_val;
        case (dec_src2_sel)
            SRC2_SE: op_src2 = se_imm;
            SRC2_ZE: op_src2 = ze_imm;
            default: op_src2 = b_val;
        endcase
    end

    // Priority: flush > stall > load; illegal is a single-cycle pulse in all cases.
    always_comb begin
        valid_d       = valid_q;
        alu_op_d      = alu_op_q;
        src1_d        = src1_q;
        src2_d        = src2_q;
        shamt_d       = shamt_q;
        rt_fwd_d      = rt_fwd_q;
        illegal_d     = 1'b0;
        illegal_cnt_d = illegal_cnt_q;
        if (bus.flush || (!bus.stall && (!bus.valid_in || !dec_legal))) begin
            valid_d  = 1'b0;
            alu_op_d = ALU_AND;
            src1_d   = '0;
            src2_d   = '0;
            shamt_d  = 5'd0;
            rt_fwd_d = '0;
            if (!bus.flush && bus.valid_in) begin
                illegal_d = 1'b1;
                if (illegal_cnt_q != '1) illegal_cnt_d = illegal_cnt_q + CNT_ONE;
            end
        end else if (!bus.stall) begin
            valid_d  = 1'b1;
            alu_op_d = dec_op;
            src1_d   = op_src1;
            src2_d   = op_src2;
            shamt_d  = dec_shamt;
            rt_fwd_d = b_val;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its _d value from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q       <= 1'b0;
            alu_op_q      <= ALU_AND;
            src1_q        <= '0;
            src2_q        <= '0;
            shamt_q       <= 5'd0;
            rt_fwd_q      <= '0;
            illegal_q     <= 1'b0;
            illegal_cnt_q <= '0;
        end else begin
            valid_q       <= valid_d;
            alu_op_q      <= alu_op_d;
            src1_q        <= src1_d;
            src2_q        <= src2_d;
            shamt_q       <= shamt_d;
            rt_fwd_q      <= rt_fwd_d;
            illegal_q     <= illegal_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign bus.valid_out   = valid_q;
    assign bus.ALUOp       = alu_op_q;
    assign bus.src1        = src1_q;
    assign bus.src2        = src2_q;
    assign bus.shamt       = shamt_q;
    assign bus.rt_fwd      = rt_fwd_q;
    assign bus.illegal     = illegal_q;
    assign bus.illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized bench for alu_issue_stage against a table-driven instruction model.
module tb_alu_issue_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_issue_stage_if #(.bit_size(32), .cnt_size(8)) bus ();
    alu_issue_stage #(.bit_size(32), .cnt_size(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    // s2_kind: 0 = forwarded rt, 1 = sign-extended imm, 2 = zero-extended imm
    // sh_kind: 0 = none, 1 = shamt field, 2 = fixed 16
    typedef struct {
        logic [3:0] op;
        bit         s1_zero;
        int         s2_kind;
        int         sh_kind;
    } entry_t;

    typedef struct {
        bit          valid;
        logic [3:0]  op;
        logic [31:0] s1, s2, rtf;
        logic [4:0]  sh;
        bit          ill;
        int          cnt;
    } mdl_t;

    entry_t isa [bit [11:0]];
    mdl_t   mdl;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, want, $time);
        end
    endtask

    function automatic bit [11:0] key_of(input logic [5:0] opc, input logic [5:0] fn);
        return {opc, (opc == 6'd0) ? fn : 6'd0};
    endfunction

    function automatic void add_isa(input logic [5:0] opc, input logic [5:0] fn,
                                    input logic [3:0] op, input bit z, input int s2k, input int shk);
        entry_t e;
        e.op = op; e.s1_zero = z; e.s2_kind = s2k; e.sh_kind = shk;
        isa[key_of(opc, fn)] = e;
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] regv);
        if (sel == 2'd1) return bus.exmem_result;
        if (sel == 2'd2) return bus.memwb_result;
        return regv;
    endfunction

    function automatic void mdl_reset();
        mdl = '{valid: 0, op: 0, s1: 0, s2: 0, rtf: 0, sh: 0, ill: 0, cnt: 0};
    endfunction

    function automatic void mdl_bubble();
        mdl.valid = 0; mdl.op = 0; mdl.s1 = 0; mdl.s2 = 0; mdl.rtf = 0; mdl.sh = 0;
    endfunction

    // Next register contents from the current inputs, following the update rules.
    function automatic void mdl_clock();
        entry_t e;
        logic [31:0] a, b;
        bit [11:0] k;
        mdl.ill = 0;
        if (bus.flush) begin
            mdl_bubble();
        end else if (bus.stall) begin
            // hold
        end else if (!bus.valid_in) begin
            mdl_bubble();
        end else begin
            k = key_of(bus.opcode, bus.funct);
            if (!isa.exists(k)) begin
                mdl_bubble();
                mdl.ill = 1;
                if (mdl.cnt < 255) mdl.cnt++;
            end else begin
                e = isa[k];
                a = pick(bus.fwd_a_sel, bus.rs_data);
                b = pick(bus.fwd_b_sel, bus.rt_data);
                mdl.valid = 1;
                mdl.op    = e.op;
                mdl.s1    = e.s1_zero ? 32'd0 : a;
                mdl.s2    = (e.s2_kind == 1) ? 32'(signed'(bus.imm16)) :
                            (e.s2_kind == 2) ? {16'd0, bus.imm16} : b;
                mdl.sh    = (e.sh_kind == 1) ? bus.shamt_in : (e.sh_kind == 2) ? 5'd16 : 5'd0;
                mdl.rtf   = b;
            end
        end
    endfunction

    task automatic check_all(input string ctx);
        check({ctx, ".valid"}, 64'(bus.valid_out), 64'(mdl.valid));
        check({ctx, ".op"},    64'(bus.ALUOp),     64'(mdl.op));
        check({ctx, ".src1"},  64'(bus.src1),      64'(mdl.s1));
        check({ctx, ".src2"},  64'(bus.src2),      64'(mdl.s2));
        check({ctx, ".shamt"}, 64'(bus.shamt),     64'(mdl.sh));
        check({ctx, ".rtfwd"}, 64'(bus.rt_fwd),    64'(mdl.rtf));
        check({ctx, ".ill"},   64'(bus.illegal),   64'(mdl.ill));
        check({ctx, ".cnt"},   64'(bus.illegal_cnt), 64'(mdl.cnt));
    endtask

    // Inputs are stable here; model and DUT advance on the same edge.
    task automatic step(input string ctx);
        mdl_clock();
        @(posedge clk);
        #1;
        check_all(ctx);
    endtask

    task automatic set_instr(input logic [5:0] opc, input logic [5:0] fn,
                             input logic [4:0] sh, input logic [15:0] imm);
        bus.valid_in = 1; bus.opcode = opc; bus.funct = fn; bus.shamt_in = sh; bus.imm16 = imm;
        bus.stall = 0; bus.flush = 0;
    endtask

    task automatic rand_inputs(input int stall_pct, input int flush_pct);
        logic [5:0] opcs [13] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h23, 6'h2B,
                                  6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h04, 6'h0F};
        logic [5:0] fns  [11] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                  6'h26, 6'h27, 6'h2A, 6'h00, 6'h02};
        bus.valid_in     = ($urandom_range(0, 9) != 0);
        bus.opcode       = ($urandom_range(0, 9) == 0) ? 6'($urandom) : opcs[$urandom_range(0, 12)];
        bus.funct        = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fns[$urandom_range(0, 10)];
        bus.shamt_in     = 5'($urandom);
        bus.imm16        = 16'($urandom);
        bus.rs_data      = $urandom;
        bus.rt_data      = $urandom;
        bus.exmem_result = $urandom;
        bus.memwb_result = $urandom;
        bus.fwd_a_sel    = 2'($urandom);
        bus.fwd_b_sel    = 2'($urandom);
        bus.stall        = ($urandom_range(0, 99) < stall_pct);
        bus.flush        = ($urandom_range(0, 99) < flush_pct);
    endtask

    initial begin
        add_isa(6'h00, 6'h20, 4'b0010, 0, 0, 0); add_isa(6'h00, 6'h21, 4'b0010, 0, 0, 0);
        add_isa(6'h00, 6'h22, 4'b0110, 0, 0, 0); add_isa(6'h00, 6'h23, 4'b0110, 0, 0, 0);
        add_isa(6'h00, 6'h24, 4'b0000, 0, 0, 0); add_isa(6'h00, 6'h25, 4'b0001, 0, 0, 0);
        add_isa(6'h00, 6'h26, 4'b1101, 0, 0, 0); add_isa(6'h00, 6'h27, 4'b1100, 0, 0, 0);
        add_isa(6'h00, 6'h2A, 4'b0111, 0, 0, 0);
        add_isa(6'h00, 6'h00, 4'b1001, 1, 0, 1); add_isa(6'h00, 6'h02, 4'b1110, 1, 0, 1);
        add_isa(6'h08, 0, 4'b0010, 0, 1, 0); add_isa(6'h09, 0, 4'b0010, 0, 1, 0);
        add_isa(6'h23, 0, 4'b0010, 0, 1, 0); add_isa(6'h2B, 0, 4'b0010, 0, 1, 0);
        add_isa(6'h0A, 0, 4'b0111, 0, 1, 0);
        add_isa(6'h0C, 0, 4'b0000, 0, 2, 0); add_isa(6'h0D, 0, 4'b0001, 0, 2, 0);
        add_isa(6'h0E, 0, 4'b1101, 0, 2, 0);
        add_isa(6'h04, 0, 4'b0110, 0, 0, 0); add_isa(6'h05, 0, 4'b0110, 0, 0, 0);
        add_isa(6'h0F, 0, 4'b1001, 1, 2, 2);

        rst = 1'b1;
        bus.valid_in = 0; bus.opcode = 0; bus.funct = 0; bus.shamt_in = 0; bus.imm16 = 0;
        bus.rs_data = 0; bus.rt_data = 0; bus.fwd_a_sel = 0; bus.fwd_b_sel = 0;
        bus.exmem_result = 0; bus.memwb_result = 0; bus.stall = 0; bus.flush = 0;
        mdl_reset();
        @(negedge clk);
        check_all("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // add with register-file operands
        set_instr(6'h00, 6'h20, 5'd9, 16'h0);
        bus.rs_data = 5; bus.rt_data = 7;
        step("add");
        check("add.op_k", 64'(bus.ALUOp), 64'h2);
        check("add.src1_k", 64'(bus.src1), 64'd5);
        check("add.src2_k", 64'(bus.src2), 64'd7);

        // asynchronous reset mid-cycle clears everything before the next edge
        #2 rst = 1'b1;
        #1;
        mdl_reset();
        check_all("async_rst");
        #1 rst = 1'b0;

        set_instr(6'h08, 6'h3F, 5'd0, 16'hFFFF);
        bus.fwd_a_sel = 2'b01; bus.exmem_result = 10;
        step("addi_fwd");
        check("addi.src1_k", 64'(bus.src1), 64'd10);
        check("addi.src2_k", 64'(bus.src2), 64'hFFFF_FFFF);

        set_instr(6'h0D, 6'h00, 5'd0, 16'hFFFF);
        step("ori");
        check("ori.src2_k", 64'(bus.src2), 64'h0000_FFFF);
        check("ori.op_k", 64'(bus.ALUOp), 64'h1);

        set_instr(6'h0F, 6'h00, 5'd0, 16'h1234);
        step("lui");
        check("lui.shamt_k", 64'(bus.shamt), 64'd16);
        check("lui.src2_k", 64'(bus.src2), 64'h1234);

        set_instr(6'h00, 6'h00, 5'd3, 16'h0);
        bus.fwd_a_sel = 2'b00; bus.fwd_b_sel = 2'b10; bus.memwb_result = 32'h8000_0001;
        step("sll");
        check("sll.shamt_k", 64'(bus.shamt), 64'd3);

        set_instr(6'h00, 6'h00, 5'd0, 16'h0);
        bus.fwd_b_sel = 2'b00; bus.rs_data = 0; bus.rt_data = 0;
        step("nop");
        check("nop.valid_k", 64'(bus.valid_out), 64'd1);
        check("nop.op_k", 64'(bus.ALUOp), 64'h9);

        for (int i = 0; i < 3; i++) begin
            rand_inputs(100, 0);
            step("stall");
        end
        rand_inputs(100, 100);
        step("stall_flush");
        check("stall_flush.valid_k", 64'(bus.valid_out), 64'd0);

        for (int i = 0; i < 260; i++) begin
            set_instr(6'h3F, 6'($urandom), 5'd0, 16'($urandom));
            if (i == 100) begin
                bus.flush = 1;
                step("ill_flush");
                check("ill_flush.ill_k", 64'(bus.illegal), 64'd0);
            end else begin
                step("illegal");
            end
        end
        check("ill.sat_k", 64'(bus.illegal_cnt), 64'd255);
        set_instr(6'h3F, 6'h0, 5'd0, 16'h0);
        bus.flush = 1;
        step("ill_flush_sat");

        for (int i = 0; i < 400; i++) begin
            rand_inputs(15, 8);
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
